// File: rtl/sdr_sched_16_if.sv
// Request/grant/refresh bundle between sdr_sched_16 and its environment.
// master drives requests and acknowledges; slave (the scheduler) drives selection and refresh.
interface sdr_sched_16_if;
  logic [0:15] req_i;
  logic        accept_i;
  logic        cmd_aref_i;
  logic [0:15] fifo_sel_o;
  logic [1:0]  fifo_sel_domain_o;
  logic        refresh_req_o;
  logic        rfr_overrun_o;

  modport master (
    output req_i, accept_i, cmd_aref_i,
    input  fifo_sel_o, fifo_sel_domain_o, refresh_req_o, rfr_overrun_o
  );

  modport slave (
    input  req_i, accept_i, cmd_aref_i,
    output fifo_sel_o, fifo_sel_domain_o, refresh_req_o, rfr_overrun_o
  );
endinterface

// File: rtl/sdr_sched_16.sv
// 16-channel request scheduler and auto-refresh timer for fsm_sdr_16.
// Define SDR_SCHED_RR_EN for round-robin arbitration; otherwise fixed lowest-index priority.
module sdr_sched_16 #(
  parameter int unsigned rfr_period = 390,
  parameter logic [31:0] domain_map = 32'h0000_0000
) (
  input logic           sdram_clk,
  input logic           sdram_rst,
  sdr_sched_16_if.slave bus
);
  localparam int unsigned CntW = $clog2(rfr_period);
  localparam logic [CntW-1:0] RcntLoad = CntW'(rfr_period - 1);

  typedef enum logic [1:0] {StArb, StGrant, StGap} arb_st_e;

  arb_st_e         state_q, state_d;
  logic [3:0]      win_q, win_d;
  logic [0:15]     sel_q, sel_d;
  logic [1:0]      dom_q, dom_d;
  logic [3:0]      ptr_q;
  logic [CntW-1:0] rcnt_q;
  logic            refresh_q, overrun_q;
  logic            expire;
  logic            found;
  logic [3:0]      pick, cand;

`ifdef SDR_SCHED_RR_EN
  logic [3:0] ptr_d;

  always_ff @(posedge sdram_clk) begin
    if (sdram_rst) ptr_q <= 4'd0;
    else           ptr_q <= ptr_d;
  end
`else
  assign ptr_q = 4'd0;
`endif

  // First requester at or after ptr, wrapping modulo 16.
  always_comb begin
    found = 1'b0;
    pick  = 4'd0;
    cand  = 4'd0;
    for (int i = 0; i < 16; i++) begin
      cand = ptr_q + 4'(i);
      if (!found && bus.req_i[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    sel_d   = sel_q;
    dom_d   = dom_q;
`ifdef SDR_SCHED_RR_EN
    ptr_d   = ptr_q;
`endif
    unique case (state_q)
      StArb: begin
        if (!refresh_q && found) begin
          win_d       = pick;
          sel_d       = '0;
          sel_d[pick] = 1'b1;
          dom_d       = domain_map[{pick, 1'b0} +: 2];
          state_d     = StGrant;
        end
      end
      StGrant: begin
        // Accept beats withdrawal when both land in the same cycle.
        if (bus.accept_i) begin
          sel_d   = '0;
          dom_d   = 2'b00;
          state_d = StGap;
`ifdef SDR_SCHED_RR_EN
          ptr_d   = win_q + 4'd1;
`endif
        end else if (refresh_q || !bus.req_i[win_q]) begin
          sel_d   = '0;
          dom_d   = 2'b00;
          state_d = StArb;
        end
      end
      StGap:   state_d = StArb;
      default: begin
        sel_d   = '0;
        dom_d   = 2'b00;
        state_d = StArb;
      end
    endcase
  end

  always_ff @(posedge sdram_clk) begin
    if (sdram_rst) begin
      state_q <= StArb;
      win_q   <= 4'd0;
      sel_q   <= '0;
      dom_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      sel_q   <= sel_d;
      dom_q   <= dom_d;
    end
  end

  assign expire = (rcnt_q == '0);

  // An acknowledge never restarts the period; a fresh expiry outranks it.
  always_ff @(posedge sdram_clk) begin
    if (sdram_rst) begin
      rcnt_q    <= RcntLoad;
      refresh_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      rcnt_q <= expire ? RcntLoad : rcnt_q - CntW'(1);
      if (expire) begin
        refresh_q <= 1'b1;
        if (refresh_q) overrun_q <= 1'b1;
      end else if (bus.cmd_aref_i) begin
        refresh_q <= 1'b0;
      end
    end
  end

  assign bus.fifo_sel_o        = sel_q;
  assign bus.fifo_sel_domain_o = dom_q;
  assign bus.refresh_req_o     = refresh_q;
  assign bus.rfr_overrun_o     = overrun_q;
endmodule

// File: tb/tb_sdr_sched_16.sv
// Directed bench for sdr_sched_16: refresh timing, arbitration, masking, domain tags and reset.
module tb_sdr_sched_16;
  logic sdram_clk = 1'b0;
  logic sdram_rst;
  int   n_vec = 0;
  int   n_err = 0;

  sdr_sched_16_if rf_if ();
  sdr_sched_16_if arb_if ();

  sdr_sched_16 #(.rfr_period(16), .domain_map(32'hE4E4_E4E4)) u_rf (
    .sdram_clk(sdram_clk),
    .sdram_rst(sdram_rst),
    .bus      (rf_if)
  );

  sdr_sched_16 #(.rfr_period(1000), .domain_map(32'h1B1B_1B1B)) u_arb (
    .sdram_clk(sdram_clk),
    .sdram_rst(sdram_rst),
    .bus      (arb_if)
  );

  always #5 sdram_clk = ~sdram_clk;

  task automatic step();
    @(posedge sdram_clk);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  // After return we sit just past the reset edge (cycle 0) with reset released.
  task automatic do_reset();
    sdram_rst         = 1'b1;
    rf_if.req_i       = '0;
    rf_if.accept_i    = 1'b0;
    rf_if.cmd_aref_i  = 1'b0;
    arb_if.req_i      = '0;
    arb_if.accept_i   = 1'b0;
    arb_if.cmd_aref_i = 1'b0;
    step();
    sdram_rst = 1'b0;
  endtask

  function automatic logic [0:15] oh(input int ch);
    logic [0:15] r;
    r     = '0;
    r[ch] = 1'b1;
    return r;
  endfunction

  function automatic logic [0:15] two(input int a, input int b);
    logic [0:15] r;
    r    = '0;
    r[a] = 1'b1;
    r[b] = 1'b1;
    return r;
  endfunction

  // 32'h1B1B_1B1B: channel k carries tag 3 - (k mod 4).
  function automatic logic [1:0] arb_dom(input int ch);
    return 2'(3 - (ch % 4));
  endfunction

  task automatic test_reset();
    sdram_rst = 1'b1;
    rf_if.req_i = '1;
    step();
    do_reset();
    n_vec++; if (rf_if.fifo_sel_o !== 16'h0000) begin n_err++;
      $display("FAIL reset_sel got %h want 0000", rf_if.fifo_sel_o); end
    n_vec++; if (rf_if.fifo_sel_domain_o !== 2'b00) begin n_err++;
      $display("FAIL reset_dom got %b want 00", rf_if.fifo_sel_domain_o); end
    n_vec++; if (rf_if.refresh_req_o !== 1'b0) begin n_err++;
      $display("FAIL reset_refresh got %b want 0", rf_if.refresh_req_o); end
    n_vec++; if (rf_if.rfr_overrun_o !== 1'b0) begin n_err++;
      $display("FAIL reset_overrun got %b want 0", rf_if.rfr_overrun_o); end
  endtask

  task automatic test_refresh();
    do_reset();
    steps(15);
    n_vec++; if (rf_if.refresh_req_o !== 1'b0) begin n_err++;
      $display("FAIL refresh_c15 got %b want 0", rf_if.refresh_req_o); end
    step();
    n_vec++; if (rf_if.refresh_req_o !== 1'b1) begin n_err++;
      $display("FAIL refresh_c16 got %b want 1", rf_if.refresh_req_o); end
    steps(4);
    rf_if.cmd_aref_i = 1'b1;
    n_vec++; if (rf_if.refresh_req_o !== 1'b1) begin n_err++;
      $display("FAIL refresh_c20 got %b want 1", rf_if.refresh_req_o); end
    step();
    rf_if.cmd_aref_i = 1'b0;
    n_vec++; if (rf_if.refresh_req_o !== 1'b0) begin n_err++;
      $display("FAIL refresh_ack_c21 got %b want 0", rf_if.refresh_req_o); end
    steps(10);
    n_vec++; if (rf_if.refresh_req_o !== 1'b0) begin n_err++;
      $display("FAIL refresh_c31 got %b want 0", rf_if.refresh_req_o); end
    step();
    n_vec++; if (rf_if.refresh_req_o !== 1'b1) begin n_err++;
      $display("FAIL refresh_c32 got %b want 1", rf_if.refresh_req_o); end
    n_vec++; if (rf_if.rfr_overrun_o !== 1'b0) begin n_err++;
      $display("FAIL refresh_no_overrun got %b want 0", rf_if.rfr_overrun_o); end
  endtask

  task automatic test_overrun();
    do_reset();
    steps(31);
    n_vec++; if (rf_if.rfr_overrun_o !== 1'b0) begin n_err++;
      $display("FAIL overrun_c31 got %b want 0", rf_if.rfr_overrun_o); end
    rf_if.cmd_aref_i = 1'b1;  // lands on the expiry edge: request must survive
    step();
    rf_if.cmd_aref_i = 1'b0;
    n_vec++; if (rf_if.rfr_overrun_o !== 1'b1) begin n_err++;
      $display("FAIL overrun_c32 got %b want 1", rf_if.rfr_overrun_o); end
    n_vec++; if (rf_if.refresh_req_o !== 1'b1) begin n_err++;
      $display("FAIL ack_vs_expiry got %b want 1", rf_if.refresh_req_o); end
    step();
    rf_if.cmd_aref_i = 1'b1;
    step();
    rf_if.cmd_aref_i = 1'b0;
    n_vec++; if (rf_if.refresh_req_o !== 1'b0) begin n_err++;
      $display("FAIL overrun_ack_refresh got %b want 0", rf_if.refresh_req_o); end
    n_vec++; if (rf_if.rfr_overrun_o !== 1'b1) begin n_err++;
      $display("FAIL overrun_sticky got %b want 1", rf_if.rfr_overrun_o); end
    do_reset();
    n_vec++; if (rf_if.rfr_overrun_o !== 1'b0) begin n_err++;
      $display("FAIL overrun_cleared got %b want 0", rf_if.rfr_overrun_o); end
  endtask

  task automatic test_domain_and_reset();
    do_reset();
    rf_if.req_i = oh(2);
    n_vec++; if (rf_if.fifo_sel_o !== 16'h0000) begin n_err++;
      $display("FAIL grant_latency got %h want 0000", rf_if.fifo_sel_o); end
    step();
    n_vec++; if (rf_if.fifo_sel_o !== oh(2)) begin n_err++;
      $display("FAIL dom_sel2 got %h want %h", rf_if.fifo_sel_o, oh(2)); end
    n_vec++; if (rf_if.fifo_sel_domain_o !== 2'b10) begin n_err++;
      $display("FAIL dom_ch2 got %b want 10", rf_if.fifo_sel_domain_o); end
    step();
    sdram_rst = 1'b1;
    step();
    sdram_rst = 1'b0;
    n_vec++; if (rf_if.fifo_sel_o !== 16'h0000) begin n_err++;
      $display("FAIL midgrant_rst_sel got %h want 0000", rf_if.fifo_sel_o); end
    n_vec++; if (rf_if.fifo_sel_domain_o !== 2'b00) begin n_err++;
      $display("FAIL midgrant_rst_dom got %b want 00", rf_if.fifo_sel_domain_o); end
    rf_if.req_i = oh(3);
    step();
    n_vec++; if (rf_if.fifo_sel_domain_o !== 2'b11) begin n_err++;
      $display("FAIL dom_ch3 got %b want 11", rf_if.fifo_sel_domain_o); end
  endtask

  task automatic test_rr_sweep();
    int exp_ch;
    do_reset();
    arb_if.req_i = '1;
    step();
    for (int k = 0; k <= 16; k++) begin
`ifdef SDR_SCHED_RR_EN
      exp_ch = k % 16;
`else
      exp_ch = 0;
`endif
      n_vec++; if (arb_if.fifo_sel_o !== oh(exp_ch)) begin n_err++;
        $display("FAIL sweep_grant k=%0d got %h want %h", k, arb_if.fifo_sel_o, oh(exp_ch)); end
      n_vec++; if (arb_if.fifo_sel_domain_o !== arb_dom(exp_ch)) begin n_err++;
        $display("FAIL sweep_dom k=%0d got %b want %b", k, arb_if.fifo_sel_domain_o,
                 arb_dom(exp_ch)); end
      step();
      arb_if.accept_i = 1'b1;
      step();
      arb_if.accept_i = 1'b0;
      n_vec++; if (arb_if.fifo_sel_o !== 16'h0000) begin n_err++;
        $display("FAIL sweep_gap k=%0d got %h want 0000", k, arb_if.fifo_sel_o); end
      steps(2);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    arb_if.req_i = oh(12);
    step();
    n_vec++; if (arb_if.fifo_sel_o !== oh(12)) begin n_err++;
      $display("FAIL wrap_setup got %h want %h", arb_if.fifo_sel_o, oh(12)); end
    arb_if.accept_i = 1'b1;
    step();
    arb_if.accept_i = 1'b0;
    arb_if.req_i    = two(3, 12);
    steps(2);
    n_vec++; if (arb_if.fifo_sel_o !== oh(3)) begin n_err++;
      $display("FAIL wrap_ch3 got %h want %h", arb_if.fifo_sel_o, oh(3)); end
    arb_if.accept_i = 1'b1;
    step();
    arb_if.accept_i = 1'b0;
    steps(2);
`ifdef SDR_SCHED_RR_EN
    n_vec++; if (arb_if.fifo_sel_o !== oh(12)) begin n_err++;
      $display("FAIL wrap_next got %h want %h", arb_if.fifo_sel_o, oh(12)); end
`else
    n_vec++; if (arb_if.fifo_sel_o !== oh(3)) begin n_err++;
      $display("FAIL wrap_next got %h want %h", arb_if.fifo_sel_o, oh(3)); end
`endif
  endtask

  task automatic test_withdraw();
    do_reset();
    arb_if.req_i = oh(7);
    step();
    arb_if.req_i = oh(9);
    step();
    n_vec++; if (arb_if.fifo_sel_o !== 16'h0000) begin n_err++;
      $display("FAIL withdraw_sel got %h want 0000", arb_if.fifo_sel_o); end
    step();
    n_vec++; if (arb_if.fifo_sel_o !== oh(9)) begin n_err++;
      $display("FAIL withdraw_regrant got %h want %h", arb_if.fifo_sel_o, oh(9)); end
  endtask

  task automatic test_refresh_mask();
    do_reset();
    rf_if.req_i = oh(5);
    steps(16);
    n_vec++; if (rf_if.fifo_sel_o !== oh(5)) begin n_err++;
      $display("FAIL mask_held got %h want %h", rf_if.fifo_sel_o, oh(5)); end
    step();
    n_vec++; if (rf_if.fifo_sel_o !== 16'h0000) begin n_err++;
      $display("FAIL mask_withdraw got %h want 0000", rf_if.fifo_sel_o); end
    rf_if.req_i = two(5, 6);  // ptr must still be 0, so 5 keeps priority
    step();
    rf_if.cmd_aref_i = 1'b1;
    step();
    rf_if.cmd_aref_i = 1'b0;
    n_vec++; if (rf_if.fifo_sel_o !== 16'h0000) begin n_err++;
      $display("FAIL mask_still_idle got %h want 0000", rf_if.fifo_sel_o); end
    step();
    n_vec++; if (rf_if.fifo_sel_o !== oh(5)) begin n_err++;
      $display("FAIL mask_regrant got %h want %h", rf_if.fifo_sel_o, oh(5)); end
  endtask

  task automatic test_accept_vs_refresh();
    do_reset();
    rf_if.req_i = oh(5);
    steps(16);
    rf_if.accept_i = 1'b1;
    step();
    rf_if.accept_i = 1'b0;
    n_vec++; if (rf_if.fifo_sel_o !== 16'h0000) begin n_err++;
      $display("FAIL accref_gap got %h want 0000", rf_if.fifo_sel_o); end
    rf_if.req_i = two(5, 6);
    step();
    rf_if.cmd_aref_i = 1'b1;
    step();
    rf_if.cmd_aref_i = 1'b0;
    step();
`ifdef SDR_SCHED_RR_EN
    n_vec++; if (rf_if.fifo_sel_o !== oh(6)) begin n_err++;
      $display("FAIL accref_next got %h want %h", rf_if.fifo_sel_o, oh(6)); end
`else
    n_vec++; if (rf_if.fifo_sel_o !== oh(5)) begin n_err++;
      $display("FAIL accref_next got %h want %h", rf_if.fifo_sel_o, oh(5)); end
`endif
  endtask

  initial begin
    test_reset();
    test_refresh();
    test_overrun();
    test_domain_and_reset();
    test_rr_sweep();
    test_wrap();
    test_withdraw();
    test_refresh_mask();
    test_accept_vs_refresh();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/sdr_sched_16.md
# sdr_sched_16

Request scheduler and refresh timer in front of `fsm_sdr_16`.
- Arbitrates the 16 egress FIFO channels and presents one one-hot selection plus its clock-domain tag on the controller's `fifo_sel_i` / `fifo_sel_domain_i`.
- Generates the periodic auto-refresh request consumed by the controller and acknowledged by its `cmd_aref` pulse.
- Runs entirely in the SDRAM clock domain; channel requests arrive already synchronised.

## Interface
Parameters:
- `rfr_period`, default 390: SDRAM clocks between refresh requests; minimum 8. Counter width is `$clog2(rfr_period)`.
- `domain_map`, default 32'h0000_0000: 2-bit domain tag per channel; channel k uses bits [2k+1:2k].

Ports:
- `sdram_clk` in 1: clock; everything updates on its rising edge.
- `sdram_rst` in 1: reset. One clock; reset is synchronous and active-high.
- `req_i` in [0:15]: per-channel request (egress FIFO non-empty); bit 0 is channel 0.
- `accept_i` in 1: single-cycle pulse; the controller has taken the current selection (its idle→adr transition).
- `cmd_aref_i` in 1: refresh acknowledge; driven from the controller's `cmd_aref`.
- `fifo_sel_o` out [0:15]: one-hot grant, or all zero.
- `fifo_sel_domain_o` out 2: domain tag of the granted channel; 2'b00 when there is no grant.
- `refresh_req_o` out 1: refresh pending.
- `rfr_overrun_o` out 1: sticky flag; a refresh period expired while the previous request was still pending.

## Operation
Arbiter FSM, states ARB, GRANT, GAP; reset state ARB. The round-robin pointer `ptr` is 4 bits, reset value 0.

**ARB**
- Stays in ARB if `refresh_req_o`=1 or `req_i`=0.
- Otherwise picks the winner w: the first set `req_i` bit at or after `ptr`, searching upward modulo 16.
- Registers `fifo_sel_o` = one-hot(w) and `fifo_sel_domain_o` = `domain_map[2w+1:2w]`, then goes to GRANT.

**GRANT**
- Outputs are held stable.
- `accept_i`=1: clear the outputs, set `ptr` = (w+1) mod 16 (15 wraps to 0), go to GAP.
- Else if `refresh_req_o`=1 or `req_i[w]`=0: withdraw. Clear the outputs, leave `ptr` unchanged, go to ARB.
- `accept_i` takes priority over withdrawal when both occur in the same cycle.

**GAP**
- Outputs are zero for exactly one cycle, then ARB.
- This guarantees the controller sees a deasserted selection between jobs.

`accept_i` outside GRANT is ignored.

**Refresh timer**
- Free-running down-counter `rcnt`, loaded with `rfr_period-1` at reset.
- Decrements every cycle. At 0 it reloads `rfr_period-1` and sets `refresh_req_o`.
- If `refresh_req_o` is already 1 at expiry, `rfr_overrun_o` is set and stays set until reset.
- `cmd_aref_i`=1 clears `refresh_req_o`, unless expiry occurs in the same cycle; the new request wins and the output stays 1.
- An acknowledge does not restart `rcnt`.
- `cmd_aref_i` pulses during controller initialisation are treated the same way (clear if pending, otherwise no effect).

**Reset**
- Asserting `sdram_rst` at any time, including mid-grant, forces on the next edge: ARB, `ptr`=0, all outputs 0, `rcnt`=`rfr_period-1`.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- Grant latency: `req_i` sampled in ARB at edge n → `fifo_sel_o` valid after edge n+1.
- Minimum grant-to-grant spacing: `accept_i` at edge n → outputs zero after n+1 (GAP), ARB at n+2, next grant visible after n+3.
- Refresh: `refresh_req_o` rises exactly `rfr_period` cycles after reset release, then every `rfr_period` cycles.
- Refresh masking: `refresh_req_o` rising at edge n withdraws an unaccepted grant after edge n+1.
- Acknowledge: `cmd_aref_i` at edge n → `refresh_req_o` low after edge n+1.

## Configuration
- `SDR_SCHED_RR_EN` defined: round-robin arbitration exactly as described; `ptr` advances on accept.
- `SDR_SCHED_RR_EN` not defined: fixed priority. The lowest-index requesting channel always wins and `ptr` is held at 0 (the register may be removed). All other behaviour, including GAP and refresh masking, is unchanged.

## Test plan
- Reset release, `req_i`=0, `rfr_period`=16 → `refresh_req_o` rises on cycle 16; `cmd_aref_i` pulse at cycle 20 → low at cycle 21; rises again at cycle 32.
- `req_i`=16'hFFFF held, `accept_i` 2 cycles after each grant (RR build) → grants channels 0,1,2,…,15,0 in order, each followed by one all-zero cycle.
- `req_i` has bits 3 and 12 set, `ptr`=13 → channel 3 wins after wrap. Non-RR build, same stimulus → channel 3 always wins.
- Grant to channel 5 outstanding, then `refresh_req_o` rises → `fifo_sel_o`=0 next cycle with `ptr` unchanged; after `cmd_aref_i`, channel 5 is re-granted. Repeat with `accept_i` in the same cycle as refresh → accept wins, GAP entered.
- No `cmd_aref_i` for 2 periods → `rfr_overrun_o`=1 at second expiry and remains 1 after a later ack; `sdram_rst` clears it.
- `domain_map`=32'hE4E4_E4E4, grant channel 2 → `fifo_sel_domain_o`=2'b10. `sdram_rst` mid-GRANT → all outputs zero next cycle.
